// File: rtl/f5_pkg.sv
// Constants and FSM state type shared by the F5 buffer writer, this reader and F6 control.
package f5_pkg;
    localparam int F5_N_BANK     = 16;
    localparam int F5_N_ADDR     = 25;
    localparam int F5_DATA_W     = 16;
    localparam int F5_RD_LAT     = 3;
    localparam int F5_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } f5_rd_state_e;
endpackage

// File: rtl/f5_rd_fifo.sv
// First-word fall-through sync FIFO for the reader output stream; the head is forced to
// zero while empty so the stream outputs read as zero after reset.
module f5_rd_fifo #(
    parameter  int WIDTH = 17,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/f5_ram_reader.sv
// Walks the F5 feature buffer bank-major, re-times its skewed read port and streams the
// 400 words to the F6 MAC over valid/ready with credit-based backpressure.
module f5_ram_reader
    import f5_pkg::*;
#(
    parameter  int DATA_W     = F5_DATA_W,
    parameter  int N_BANK     = F5_N_BANK,
    parameter  int N_ADDR     = F5_N_ADDR,
    parameter  int RD_LAT     = F5_RD_LAT,
    parameter  int FIFO_DEPTH = F5_FIFO_DEPTH,
    localparam int SEL_W      = $clog2(N_BANK),
    localparam int ADDR_W     = $clog2(N_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  f5_sel,
    output logic [ADDR_W-1:0] f5_raddr,
    input  logic [DATA_W-1:0] f5_rdata,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    f5_rd_state_e      state;
    logic [SEL_W-1:0]  sel_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] last_p;
    logic              last_acc;
    logic              at_last;
    logic              issue;
    logic              pop;
    logic              credit_ok;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic [DATA_W:0]   fifo_head;

    function automatic int count_ones(input logic [RD_LAT-1:0] v);
        int n = 0;
        for (int i = 0; i < RD_LAT; i++) n += int'(v[i]);
        return n;
    endfunction

    // The sel counter is the read port: a word is issued in the cycle its sel is driven
    // and the counter advances, so sel holds steady whenever issue stalls.
    assign f5_sel  = sel_cnt;
    assign at_last = (sel_cnt == SEL_W'(N_BANK - 1)) && (addr_cnt == ADDR_W'(N_ADDR - 1));
    assign pop     = dout_valid && dout_ready;

    // A slot freed by this cycle's pop is usable, which sustains one word per cycle.
    assign credit_ok = (int'(fifo_count) + count_ones(vld_p) + 1) <= (FIFO_DEPTH + int'(pop));
    assign issue     = (state == ISSUE) && credit_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sel_cnt  <= '0;
            addr_cnt <= '0;
            f5_raddr <= '0;
            vld_p    <= '0;
            last_p   <= '0;
            last_acc <= 1'b0;
        end else begin
            done     <= 1'b0;
            // raddr skew stage: address follows its sel by one cycle
            f5_raddr <= addr_cnt;
            // return-tag pipe: bit RD_LAT-1 marks f5_rdata belonging to an issued word
            vld_p    <= (vld_p << 1) | RD_LAT'(issue);
            last_p   <= (last_p << 1) | RD_LAT'(issue && at_last);
            if (pop && dout_last) last_acc <= 1'b1;

            if (issue && !at_last) begin
                if (addr_cnt == ADDR_W'(N_ADDR - 1)) begin
                    addr_cnt <= '0;
                    sel_cnt  <= sel_cnt + 1'b1;
                end else begin
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        sel_cnt  <= '0;
                        addr_cnt <= '0;
                        last_acc <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (issue && at_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty && (vld_p == '0) && last_acc) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // output buffer stage: last flag rides above the data bits
    f5_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p[RD_LAT-1]),
        .wdata ({last_p[RD_LAT-1], f5_rdata}),
        .pop   (pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign dout_valid = !fifo_empty;
    assign dout       = fifo_head[DATA_W-1:0];
    assign dout_last  = fifo_head[DATA_W];
endmodule

// File: tb/tb_f5_ram_reader.sv
// Bench for f5_ram_reader: buffer model with the skewed read contract, scoreboard of the
// 400-word stream, table of pass scenarios plus reset and stall sequences.
module tb_f5_ram_reader;
    import f5_pkg::*;

    localparam int DW  = F5_DATA_W;
    localparam int NB  = F5_N_BANK;
    localparam int NA  = F5_N_ADDR;
    localparam int LAT = F5_RD_LAT;
    localparam int DEP = F5_FIFO_DEPTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [3:0]    f5_sel;
    logic [4:0]    f5_raddr;
    logic [DW-1:0] f5_rdata;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          dout_last;

    f5_ram_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .f5_sel     (f5_sel),
        .f5_raddr   (f5_raddr),
        .f5_rdata   (f5_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int mode;
        int hold;
        bit poke;
        int budget;
        bit fast;
    } vec_t;

    exp_t exp_q[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   n_acc = 0;
    int   n_done = 0;
    int   ready_mode = 0;

    function automatic logic [DW-1:0] word_of(input int b, input int a);
        logic [3:0] bb;
        logic [4:0] aa;
        bb = 4'(b);
        aa = 5'(a);
        return {bb, aa, 7'h0};
    endfunction

    function automatic void check(input string nm, input longint act, input longint exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Buffer model: sel in cycle t, raddr in t+1, data in t+LAT.
    logic [DW-1:0] bram [NB][NA];
    logic [3:0]    sel_d1 = '0;
    logic [DW-1:0] rd_m1 = '0;
    logic [DW-1:0] rd_m2 = '0;
    always @(posedge clk) begin
        sel_d1 <= f5_sel;
        rd_m1  <= bram[sel_d1][f5_raddr];
        rd_m2  <= rd_m1;
    end
    assign f5_rdata = rd_m2;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ($urandom_range(0, 99) >= 30);
            default: dout_ready = 1'b0;
        endcase
    end

    // Stream monitor / scoreboard consumer.
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v <= 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", dout_valid, 1);
                check("stall_data", dout, held_d);
                check("stall_last", dout_last, held_l);
            end
            if (dout_valid && dout_ready) begin
                n_acc <= n_acc + 1;
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word", dout, e.data);
                    check("last", dout_last, e.last);
                end
            end
            if (done) begin
                n_done <= n_done + 1;
                check("busy_at_done", busy, 0);
            end
            held_v <= dout_valid && !dout_ready;
            held_d <= dout;
            held_l <= dout_last;
        end
    end

    task automatic kick();
        start = 1'b1;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < NA; a++)
                exp_q.push_back('{data: word_of(b, a), last: (b == NB - 1) && (a == NA - 1)});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", f5_sel, 0);
        check("rst_raddr", f5_raddr, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        check("rst_dout", dout, 0);
    endtask

    task automatic run_pass(input vec_t v);
        int first_v = -1;
        int got_done = -1;
        int nvalid = 0;
        int acc0 = n_acc;
        int done0 = n_done;
        ready_mode = (v.hold > 0) ? 2 : v.mode;
        kick();
        for (int c = 0; c < v.budget && got_done < 0; c++) begin
            @(negedge clk);
            if (v.hold > 0 && c == v.hold - 1) begin
                check("stall_fifo_count", dut.u_fifo.count, DEP);
                check("stall_in_flight", dut.vld_p, 0);
                check("stall_head", dout, word_of(0, 0));
                check("stall_no_accept", n_acc - acc0, 0);
                ready_mode = v.mode;
            end
            if (dout_valid) nvalid++;
            if (dout_valid && first_v < 0) first_v = c;
            if (done) got_done = c;
            start = v.poke && (c == 200 || done);
        end
        @(negedge clk);
        start = 1'b0;
        check("first_valid_cycle", first_v, LAT + 1);
        check("done_seen", got_done >= 0, 1);
        if (v.fast) begin
            check("done_within_bound", (got_done >= 0) && (got_done <= 400 + LAT + 3), 1);
            check("no_gaps", nvalid, 400);
        end
        repeat (20) @(negedge clk);
        check("accepted_words", n_acc - acc0, 400);
        check("done_pulses", n_done - done0, 1);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_valid", dout_valid, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   acc0;
        int   done0;
        vecs[0] = '{mode: 0, hold: 0,  poke: 1'b0, budget: 1000, fast: 1'b1};
        vecs[1] = '{mode: 1, hold: 0,  poke: 1'b0, budget: 3000, fast: 1'b0};
        vecs[2] = '{mode: 0, hold: 50, poke: 1'b0, budget: 1000, fast: 1'b0};
        vecs[3] = '{mode: 1, hold: 0,  poke: 1'b1, budget: 3000, fast: 1'b0};
        vecs[4] = '{mode: 0, hold: 0,  poke: 1'b1, budget: 1000, fast: 1'b1};

        for (int b = 0; b < NB; b++)
            for (int a = 0; a < NA; a++)
                bram[b][a] = word_of(b, a);

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_pass(vecs[i]);

        // Reset in the middle of a pass, then a clean full pass.
        ready_mode = 0;
        acc0 = n_acc;
        done0 = n_done;
        kick();
        for (int c = 0; c < 1000 && (n_acc - acc0) < 137; c++) begin
            @(negedge clk);
            #1;
        end
        check("reach_word_137", n_acc - acc0, 137);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        check("rst_fifo_count", dut.u_fifo.count, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_no_done", n_done - done0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_pass(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
